// File: rtl/cordic_vectoring_iter_pkg.sv
// Shared constants, state encoding and helpers for the CORDIC vectoring blocks.
package cordic_pkg;

    localparam int FRAC_BITS = 12;
    localparam int ATAN_N    = 12;
    localparam int CNT_W     = 4;
    localparam int SEXT_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // atan(2^-i) in Q2.12 radians; entries past the table end read as zero.
    function automatic logic signed [15:0] atan_lut(input logic [CNT_W-1:0] i);
        case (i)
            4'd0:    atan_lut = 16'sd3217;
            4'd1:    atan_lut = 16'sd1899;
            4'd2:    atan_lut = 16'sd1003;
            4'd3:    atan_lut = 16'sd509;
            4'd4:    atan_lut = 16'sd256;
            4'd5:    atan_lut = 16'sd128;
            4'd6:    atan_lut = 16'sd64;
            4'd7:    atan_lut = 16'sd32;
            4'd8:    atan_lut = 16'sd16;
            4'd9:    atan_lut = 16'sd8;
            4'd10:   atan_lut = 16'sd4;
            4'd11:   atan_lut = 16'sd2;
            default: atan_lut = 16'sd0;
        endcase
    endfunction

    // Sign-extend the low w bits of v to the full SEXT_W width; callers cast down to IW.
    function automatic logic signed [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v, input int w);
        logic signed [SEXT_W-1:0] t;
        t = v << (SEXT_W - w);
        return t >>> (SEXT_W - w);
    endfunction

endpackage

// File: rtl/cordic_vectoring_iter_if.sv
// Valid/ready vector-in / result-out bundle for the iterative CORDIC vectoring core.
interface cordic_vectoring_iter_if #(
    parameter int DATA_WIDTH = 15,
    parameter int IW         = DATA_WIDTH + 2
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] X_in;
    logic signed [DATA_WIDTH-1:0] Y_in;
    logic signed [DATA_WIDTH-1:0] theta_in;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [IW-1:0]         mag_out;
    logic signed [DATA_WIDTH-1:0] theta_out;

    modport master (
        output in_valid, X_in, Y_in, theta_in, out_ready,
        input  in_ready, out_valid, mag_out, theta_out
    );

    modport slave (
        input  in_valid, X_in, Y_in, theta_in, out_ready,
        output in_ready, out_valid, mag_out, theta_out
    );
endinterface

// File: rtl/cordic_vectoring_iter_microrot.sv
// One combinational CORDIC vectoring micro-rotation; rotates toward y = 0.
module cordic_microrot #(
    parameter int IW         = 17,
    parameter int DATA_WIDTH = 15,
    parameter int SH_W       = 4
) (
    input  logic signed [IW-1:0]         x,
    input  logic signed [IW-1:0]         y,
    input  logic signed [DATA_WIDTH-1:0] z,
    input  logic        [SH_W-1:0]       shift,
    input  logic signed [DATA_WIDTH-1:0] atan,
    output logic signed [IW-1:0]         x_next,
    output logic signed [IW-1:0]         y_next,
    output logic signed [DATA_WIDTH-1:0] z_next
);
    logic signed [IW-1:0] x_sh;
    logic signed [IW-1:0] y_sh;

    // Direction follows the sign of y; both updates use the pre-rotation x and y.
    always_comb begin
        x_sh = x >>> shift;
        y_sh = y >>> shift;
        if (!y[IW-1]) begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + atan;
        end else begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - atan;
        end
    end
endmodule

// File: rtl/cordic_vectoring_iter.sv
// Folded CORDIC vectoring core: one micro-rotation per clock, result held until taken.
module cordic_vectoring_iter
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = 15,
    parameter int ITERATIONS = 12,
    parameter int IW         = DATA_WIDTH + 2
) (
    input logic                    clk,
    input logic                    rst,
    cordic_vectoring_iter_if.slave bus
);
    state_t                       state_q, state_d;
    logic        [CNT_W-1:0]      cnt_q;
    logic signed [IW-1:0]         x_q, y_q;
    logic signed [DATA_WIDTH-1:0] z_q;
    logic signed [IW-1:0]         mag_q;
    logic signed [DATA_WIDTH-1:0] theta_q;
    logic signed [IW-1:0]         x_n, y_n;
    logic signed [DATA_WIDTH-1:0] z_n;
    logic signed [DATA_WIDTH-1:0] atan_c;
    logic                         last_c;
    logic                         in_ready_c;
    logic                         out_valid_c;

    assign atan_c = DATA_WIDTH'(atan_lut(cnt_q));
    assign last_c = (cnt_q == CNT_W'(ITERATIONS - 1));

    cordic_microrot #(
        .IW         (IW),
        .DATA_WIDTH (DATA_WIDTH),
        .SH_W       (CNT_W)
    ) u_rot (
        .x      (x_q),
        .y      (y_q),
        .z      (z_q),
        .shift  (cnt_q),
        .atan   (atan_c),
        .x_next (x_n),
        .y_next (y_n),
        .z_next (z_n)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs; DONE never accepts, so no same-cycle turnaround.
    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = ITER;
            end
            ITER: begin
                if (last_c) state_d = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accept, rotate while iterating, latch results on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            mag_q   <= '0;
            theta_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q   <= IW'(sext(SEXT_W'(bus.X_in), DATA_WIDTH));
                        y_q   <= IW'(sext(SEXT_W'(bus.Y_in), DATA_WIDTH));
                        z_q   <= bus.theta_in;
                        cnt_q <= '0;
                    end
                end
                ITER: begin
                    x_q <= x_n;
                    y_q <= y_n;
                    z_q <= z_n;
                    if (last_c) begin
                        mag_q   <= x_n;
                        theta_q <= z_n;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.mag_out   = mag_q;
    assign bus.theta_out = theta_q;
endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Scoreboard bench for the iterative CORDIC vectoring core.
module tb_cordic_vectoring_iter;
    localparam int DW    = 15;
    localparam int IW    = 17;
    localparam int ITERS = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_vectoring_iter_if #(.DATA_WIDTH(DW), .IW(IW)) bus ();

    cordic_vectoring_iter #(
        .DATA_WIDTH (DW),
        .ITERATIONS (ITERS),
        .IW         (IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int mag;
        int th;
        int acc;
    } exp_t;

    exp_t q[$];
    int   chk = 0;
    int   err = 0;
    int   cyc = 0;
    bit   bp_en = 1'b0;
    logic prev_ov = 1'b0;
    int   atan_tab[12] = '{3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2};

    // floor(a / 2^i)
    function automatic int fdiv(input int a, input int i);
        int d;
        d = 1 << i;
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int wrap(input int v, input int w);
        int m, r;
        m = 1 << w;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // Reference: rotate the vector toward the +x axis, accumulating the angle used.
    task automatic model(input int x0, input int y0, input int t0, output int mag, output int th);
        int x, y, z, dx, dy;
        x = x0; y = y0; z = t0;
        for (int i = 0; i < ITERS; i++) begin
            dx = fdiv(y, i);
            dy = fdiv(x, i);
            if (y >= 0) begin
                x = x + dx; y = y - dy; z = z + atan_tab[i];
            end else begin
                x = x - dx; y = y + dy; z = z - atan_tab[i];
            end
        end
        mag = wrap(x, IW);
        th  = wrap(z, DW);
    endtask

    task automatic check(input string name, input int act, input int req);
        chk++;
        if (act != req) begin
            err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_near(input string name, input int act, input int req, input int tol);
        chk++;
        if (act < req - tol || act > req + tol) begin
            err++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, req, tol);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Random downstream backpressure during the random phase.
    always @(posedge clk) begin
        #1;
        if (bp_en) bus.out_ready = ($urandom % 3) != 0;
    end

    // Monitor: latency on the rising edge of out_valid, data compared at each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && !prev_ov) begin
                if (q.size() == 0) begin
                    chk++; err++;
                    $display("FAIL unexpected_out_valid: got 1, expected 0");
                end else begin
                    check("latency", cyc - q[0].acc, ITERS);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk++; err++;
                    $display("FAIL unexpected_result: got mag %0d, expected none", int'(bus.mag_out));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("mag_out", int'(bus.mag_out), e.mag);
                    check("theta_out", int'(bus.theta_out), e.th);
                end
            end
        end
        prev_ov = bus.out_valid;
    end

    // Present a vector and hold it until accepted; waited = cycles spent before acceptance.
    task automatic send(input int x, input int y, input int t, output int waited);
        int m, th;
        bus.X_in     = DW'(x);
        bus.Y_in     = DW'(y);
        bus.theta_in = DW'(t);
        bus.in_valid = 1'b1;
        waited = 0;
        while (!bus.in_ready && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) begin
            chk++; err++;
            $display("FAIL send_timeout: got in_ready 0, expected 1");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        model(x, y, t, m, th);
        q.push_back('{m, th, cyc});
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int mag, output int th);
        int n;
        n = 0;
        mag = 0; th = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) begin
            chk++; err++;
            $display("FAIL result_timeout: got out_valid 0, expected 1");
            return;
        end
        mag = int'(bus.mag_out);
        th  = int'(bus.theta_out);
        if (bus.out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int w, m, th, hm, ht, n;
        bus.in_valid  = 1'b1;
        bus.X_in      = 15'sd1234;
        bus.Y_in      = 15'sd77;
        bus.theta_in  = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_mag", int'(bus.mag_out), 0);
        check("rst_theta", int'(bus.theta_out), 0);

        send(1000, 0, 0, w);
        check("in_ready_drop", int'(bus.in_ready), 0);
        wait_result(m, th);
        check_near("x_axis_mag", m, 1647, 3);
        check_near("x_axis_theta", th, 0, 4);

        send(1000, 1000, 0, w);
        wait_result(m, th);
        check_near("diag_mag", m, 2329, 4);
        check_near("diag_theta", th, 3217, 4);

        send(1000, -1000, 0, w);
        wait_result(m, th);
        check_near("ndiag_mag", m, 2329, 4);
        check_near("ndiag_theta", th, -3217, 4);

        send(0, -1000, 0, w);
        wait_result(m, th);
        check_near("neg_y_mag", m, 1647, 3);
        check_near("neg_y_theta", th, -6434, 4);

        send(0, 0, 0, w);
        wait_result(m, th);
        check("zero_mag", m, 0);
        check("zero_theta", th, 7138);

        send(16383, -16384, 0, w);
        wait_result(m, th);
        check_near("fullscale_mag", m, 38153, 6);
        check_near("fullscale_theta", th, -3217, 4);

        send(-16384, 0, 0, w);
        wait_result(m, th);

        // Backpressure: result must hold while out_ready is low; new input ignored.
        bus.out_ready = 1'b0;
        send(700, -300, 100, w);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_out_valid", int'(bus.out_valid), 1);
        hm = int'(bus.mag_out);
        ht = int'(bus.theta_out);
        bus.X_in = 15'sd500; bus.Y_in = 15'sd400; bus.theta_in = '0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", int'(bus.out_valid), 1);
            check("bp_hold_mag", int'(bus.mag_out), hm);
            check("bp_hold_theta", int'(bus.theta_out), ht);
            check("bp_in_ready", int'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        send(500, 400, 0, w);
        check("bp_turnaround", w, 1);
        wait_result(m, th);

        // Abort mid-iteration: reset lands on the sixth micro-rotation edge.
        send(1200, -800, 0, w);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", int'(bus.in_ready), 1);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_mag", int'(bus.mag_out), 0);
        check("abort_theta", int'(bus.theta_out), 0);
        if (q.size() > 0) q.delete(q.size() - 1);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        send(900, 350, 50, w);
        wait_result(m, th);

        // Random vectors with random downstream stalls.
        bp_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int x, y, t;
            x = ($urandom % 8 == 0) ? -16384 : int'($urandom_range(0, 16383));
            y = int'($urandom_range(0, 32767)) - 16384;
            t = int'($urandom_range(0, 8191)) - 4096;
            send(x, y, t, w);
        end
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        bp_en = 1'b0;
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        if (q.size() != 0) begin
            chk++; err++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
        end
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end
endmodule
